ysyx_25060170_seq_ctrl: RTL and testbench
=========================================

YSYX_25060170_SEQ_CTRL -- requirements
Module: ysyx_25060170_seq_ctrl

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum consecutive cycles in any one request/wait state before forced halt.
- REQ-002 SHALL have a single clock; reset is asynchronous and active-high. Ports are clk and rst.
- REQ-003 clk  input  1  rising-edge clock.
- REQ-004 rst  input  1  asynchronous reset, active-high.
- REQ-005 ifu_req_o  output  1  instruction fetch request valid.
- REQ-006 ifu_ready_i  input  1  fetch request accepted.
- REQ-007 ifu_rvalid_i  input  1  fetched instruction valid.
- REQ-008 inst_we_o  output  1  latch the fetched instruction into the instruction register.
- REQ-009 is_load_i  input  1  decoded load; valid in EXEC.
- REQ-010 is_store_i  input  1  decoded store; valid in EXEC.
- REQ-011 is_ebreak_i  input  1  decoded ebreak; valid in EXEC.
- REQ-012 lsu_req_o  output  1  data memory request valid.
- REQ-013 lsu_ready_i  input  1  data request accepted.
- REQ-014 lsu_rvalid_i  input  1  data response or write acknowledge.
- REQ-015 gpr_we_o  output  1  qualifies the decoder register-write enable; the GPR write occurs only when this is 1.
- REQ-016 pc_we_o  output  1  PC update strobe to the IFU.
- REQ-017 halt_o  output  1  core halted; sticky.
- REQ-018 timeout_o  output  1  halt caused by timeout; sticky.
- REQ-019 state_o  output  3  current state encoding, for debug.
- REQ-020 inst_cnt_o  output  32  retired-instruction count.

Function
- REQ-021 SHALL use these state encodings: IDLE=0, IF_REQ=1, IF_WAIT=2, EXEC=3, MEM_REQ=4, MEM_WAIT=5, WB=6, HALT=7.
- REQ-022 IDLE SHALL last exactly one cycle after reset deassertion, then go to IF_REQ.
- REQ-023 IF_REQ: ifu_req_o=1. ifu_ready_i=1 goes to IF_WAIT. ifu_rvalid_i is ignored in this state.
- REQ-024 IF_WAIT: inst_we_o = ifu_rvalid_i (combinational). ifu_rvalid_i=1 goes to EXEC.
- REQ-025 EXEC SHALL last exactly one cycle. Transitions, in priority order:
  - is_ebreak_i goes to HALT.
  - else is_load_i or is_store_i goes to MEM_REQ.
  - else goes to WB.
- REQ-026 If both is_load_i and is_store_i are 1, the access SHALL be treated as a load.
- REQ-027 MEM_REQ: lsu_req_o=1. lsu_ready_i=1 goes to MEM_WAIT.
- REQ-028 MEM_WAIT: lsu_rvalid_i=1 goes to WB. lsu_rvalid_i is ignored in MEM_REQ.
- REQ-029 WB SHALL last exactly one cycle, then go to IF_REQ.
  - pc_we_o=1.
  - gpr_we_o=1 unless the instruction was a store (store flag latched in EXEC).
  - inst_cnt_o increments by 1, wrapping from 0xFFFFFFFF to 0.
- REQ-030 HALT SHALL be terminal until reset; halt_o=1 and all strobes are 0.
  - An ebreak halt performs no pc_we_o, no gpr_we_o and no count increment.
- REQ-031 wait_cnt SHALL clear on every state transition and increment each cycle spent in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT whose exit condition is false.
- REQ-032 If wait_cnt==TIMEOUT_CYCLES-1 and the exit condition is false, the next state SHALL be HALT with timeout_o=1.
  - An exit condition true on that same cycle takes priority over the timeout.
- REQ-033 Outside the states named in REQ-023 to REQ-029, ifu_req_o, lsu_req_o, inst_we_o, pc_we_o and gpr_we_o SHALL be 0.
- REQ-034 Every output except inst_we_o SHALL be a function of registered state only.

Reset
- REQ-035 rst=1 SHALL asynchronously force: state=IDLE, all strobes 0, halt_o=0, timeout_o=0, inst_cnt_o=0, wait_cnt=0.
- REQ-036 Reset asserted mid-transaction (any state) SHALL abandon the transaction with no pc_we_o or gpr_we_o pulse.
- REQ-037 After reset, the sequence SHALL restart from IDLE.

Verification
- REQ-038 Zero-wait ALU instruction: ready and rvalid tied to 1, no load/store flags → states 1,2,3,6 repeat. One pc_we_o and one gpr_we_o pulse every 4 cycles; inst_cnt_o=3 after 3 instructions.
- REQ-039 Store with lsu_rvalid_i delayed 5 cycles → MEM_WAIT held 5 cycles. WB has pc_we_o=1 and gpr_we_o=0.
- REQ-040 ebreak in EXEC → state_o=7 next cycle, halt_o=1, timeout_o=0, inst_cnt_o unchanged. State stays 7 for 100 cycles.
- REQ-041 TIMEOUT_CYCLES=4, ifu_ready_i=1, ifu_rvalid_i held 0 → IF_WAIT for 4 cycles, then HALT with timeout_o=1. Repeat the run with rvalid=1 on the 4th IF_WAIT cycle → EXEC, no timeout.
- REQ-042 rst pulsed during MEM_WAIT → state_o=0 immediately, all outputs at reset values, no WB pulse. Resumes IF_REQ 1 cycle after release.
- REQ-043 inst_cnt_o preloaded to 0xFFFFFFFF by forcing → after one WB reads 0x00000000.

Source files
------------

// File: rtl/ysyx_25060170_seq_ctrl_if.sv
// ysyx_25060170_seq_ctrl_if: fetch/memory handshake and status bundle of the sequencing controller
interface ysyx_25060170_seq_ctrl_if;
  logic        ifu_req_o;
  logic        ifu_ready_i;
  logic        ifu_rvalid_i;
  logic        inst_we_o;
  logic        is_load_i;
  logic        is_store_i;
  logic        is_ebreak_i;
  logic        lsu_req_o;
  logic        lsu_ready_i;
  logic        lsu_rvalid_i;
  logic        gpr_we_o;
  logic        pc_we_o;
  logic        halt_o;
  logic        timeout_o;
  logic [2:0]  state_o;
  logic [31:0] inst_cnt_o;
  modport master (
    output ifu_req_o, inst_we_o, lsu_req_o, gpr_we_o, pc_we_o, halt_o, timeout_o, state_o, inst_cnt_o,
    input  ifu_ready_i, ifu_rvalid_i, is_load_i, is_store_i, is_ebreak_i, lsu_ready_i, lsu_rvalid_i
  );
  modport slave (
    input  ifu_req_o, inst_we_o, lsu_req_o, gpr_we_o, pc_we_o, halt_o, timeout_o, state_o, inst_cnt_o,
    output ifu_ready_i, ifu_rvalid_i, is_load_i, is_store_i, is_ebreak_i, lsu_ready_i, lsu_rvalid_i
  );
endinterface

// File: rtl/ysyx_25060170_seq_ctrl.sv
// ysyx_25060170_seq_ctrl: multi-cycle fetch/exec/mem/writeback sequencer with wait timeout and halt
module ysyx_25060170_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  ysyx_25060170_seq_ctrl_if.master bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] IF_REQ   = 3'd1;
  localparam logic [2:0] IF_WAIT  = 3'd2;
  localparam logic [2:0] EXEC     = 3'd3;
  localparam logic [2:0] MEM_REQ  = 3'd4;
  localparam logic [2:0] MEM_WAIT = 3'd5;
  localparam logic [2:0] WB       = 3'd6;
  localparam logic [2:0] HALT     = 3'd7;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [2:0]    state, state_n;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   inst_cnt;
  logic          store_q, timeout_q, wait_st, exit_c, expire;
  // exit condition of the current wait state and timeout detection
  always_comb begin
    wait_st = state == IF_REQ || state == IF_WAIT || state == MEM_REQ || state == MEM_WAIT;
    exit_c  = state == IF_REQ  ? bus.ifu_ready_i :
              state == IF_WAIT ? bus.ifu_rvalid_i :
              state == MEM_REQ ? bus.lsu_ready_i : bus.lsu_rvalid_i;
    expire  = wait_st && !exit_c && wait_cnt == WW'(TIMEOUT_CYCLES - 1);
  end
  // next-state selection; a timeout overrides a stalled wait state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = IF_REQ;
      IF_REQ:   state_n = bus.ifu_ready_i ? IF_WAIT : IF_REQ;
      IF_WAIT:  state_n = bus.ifu_rvalid_i ? EXEC : IF_WAIT;
      EXEC:     state_n = bus.is_ebreak_i ? HALT : (bus.is_load_i || bus.is_store_i) ? MEM_REQ : WB;
      MEM_REQ:  state_n = bus.lsu_ready_i ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: state_n = bus.lsu_rvalid_i ? WB : MEM_WAIT;
      WB:       state_n = IF_REQ;
      default:  state_n = HALT;
    endcase
    if (expire) state_n = HALT;
  end
  // state, wait counter, store flag, sticky timeout and retired count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      store_q   <= 1'b0;
      timeout_q <= 1'b0;
      inst_cnt  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= state_n != state ? '0 : wait_st ? wait_cnt + 1'b1 : wait_cnt;
      if (state == EXEC) store_q <= bus.is_store_i && !bus.is_load_i;
      if (expire) timeout_q <= 1'b1;
      if (state == WB) inst_cnt <= inst_cnt + 32'd1;
    end
  end
  assign bus.ifu_req_o  = state == IF_REQ;
  assign bus.inst_we_o  = state == IF_WAIT && bus.ifu_rvalid_i;
  assign bus.lsu_req_o  = state == MEM_REQ;
  assign bus.pc_we_o    = state == WB;
  assign bus.gpr_we_o   = state == WB && !store_q;
  assign bus.halt_o     = state == HALT;
  assign bus.timeout_o  = timeout_q;
  assign bus.state_o    = state;
  assign bus.inst_cnt_o = inst_cnt;
endmodule

// File: tb/tb_ysyx_25060170_seq_ctrl.sv
// tb_ysyx_25060170_seq_ctrl: randomized transaction-plan bench for the sequencing controller
module tb_ysyx_25060170_seq_ctrl;
  typedef struct {
    logic [2:0]  st;
    logic        ir, iv, ld, sd, eb, lr, lv, store;
    logic [31:0] cnt;
  } cyc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [31:0] retired = '0;
  cyc_t plan[$];
  ysyx_25060170_seq_ctrl_if b ();
  ysyx_25060170_seq_ctrl_if bt ();
  ysyx_25060170_seq_ctrl dut (.clk(clk), .rst(rst), .bus(b));
  ysyx_25060170_seq_ctrl #(.TIMEOUT_CYCLES(4)) dut_t (.clk(clk), .rst(rst), .bus(bt));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] obs();
    return {22'd0, b.state_o, b.ifu_req_o, b.inst_we_o, b.lsu_req_o, b.pc_we_o, b.gpr_we_o,
            b.halt_o, b.timeout_o, b.inst_cnt_o};
  endfunction
  function automatic logic [63:0] expect_of(input cyc_t c);
    return {22'd0, c.st, c.st == 3'd1, c.st == 3'd2 && c.iv, c.st == 3'd4, c.st == 3'd6,
            c.st == 3'd6 && !c.store, c.st == 3'd7, 1'b0, c.cnt};
  endfunction
  function automatic cyc_t rnd(input logic [2:0] st);
    cyc_t c;
    c.st = st;
    c.ir = $urandom % 2;
    c.iv = $urandom % 2;
    c.ld = $urandom % 2;
    c.sd = $urandom % 2;
    c.eb = $urandom % 2;
    c.lr = $urandom % 2;
    c.lv = $urandom % 2;
    c.store = 1'b0;
    c.cnt = retired;
    if (st == 3'd1) c.ir = 1'b0;
    if (st == 3'd2) c.iv = 1'b0;
    if (st == 3'd4) c.lr = 1'b0;
    if (st == 3'd5) c.lv = 1'b0;
    return c;
  endfunction
  // kind: 0 alu, 1 load, 2 store, 3 load+store (acts as load), 4 ebreak
  task automatic gen(input int kind, input int dr, input int dv, input int dq, input int dw);
    cyc_t c;
    for (int i = 0; i <= dr; i++) begin c = rnd(3'd1); c.ir = i == dr; plan.push_back(c); end
    for (int i = 0; i <= dv; i++) begin c = rnd(3'd2); c.iv = i == dv; plan.push_back(c); end
    c = rnd(3'd3);
    c.eb = kind == 4;
    c.ld = kind == 1 || kind == 3;
    c.sd = kind == 2 || kind == 3;
    plan.push_back(c);
    if (kind == 4) return;
    if (kind != 0) begin
      for (int i = 0; i <= dq; i++) begin c = rnd(3'd4); c.lr = i == dq; plan.push_back(c); end
      for (int i = 0; i <= dw; i++) begin c = rnd(3'd5); c.lv = i == dw; plan.push_back(c); end
    end
    c = rnd(3'd6);
    c.store = kind == 2;
    plan.push_back(c);
    retired++;
  endtask
  task automatic run_plan();
    foreach (plan[k]) begin
      @(negedge clk);
      b.ifu_ready_i  = plan[k].ir;
      b.ifu_rvalid_i = plan[k].iv;
      b.is_load_i    = plan[k].ld;
      b.is_store_i   = plan[k].sd;
      b.is_ebreak_i  = plan[k].eb;
      b.lsu_ready_i  = plan[k].lr;
      b.lsu_rvalid_i = plan[k].lv;
      #1 check("cyc", obs(), expect_of(plan[k]));
    end
    plan.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst", obs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    retired = '0;
    #1 check("idle", obs(), 64'd0);
  endtask
  initial begin
    {b.ifu_ready_i, b.ifu_rvalid_i, b.is_load_i, b.is_store_i, b.is_ebreak_i, b.lsu_ready_i, b.lsu_rvalid_i} = '0;
    {bt.ifu_ready_i, bt.ifu_rvalid_i, bt.is_load_i, bt.is_store_i, bt.is_ebreak_i, bt.lsu_ready_i, bt.lsu_rvalid_i} = '0;
    do_reset();
    repeat (3) gen(0, 0, 0, 0, 0);
    repeat (40) gen($urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4, $urandom % 4);
    gen(2, 0, 0, 0, 4);
    gen(3, 1, 0, 2, 1);
    run_plan();
    gen(1, 1, 1, 1, 3);
    plan = plan[0:$-2];
    run_plan();
    do_reset();
    force dut.inst_cnt = 32'hFFFF_FFFF;
    #1 release dut.inst_cnt;
    retired = 32'hFFFF_FFFF;
    gen(0, 0, 1, 0, 0);
    gen(2, 1, 0, 0, 0);
    gen(4, $urandom % 3, $urandom % 3, 0, 0);
    repeat (100) plan.push_back(rnd(3'd7));
    run_plan();
    do_reset();
    bt.ifu_ready_i = 1'b1;
    @(negedge clk); #1 check("t_ifreq", {61'd0, bt.state_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 check("t_ifwait", {61'd0, bt.state_o}, 64'd2);
    end
    @(negedge clk); #1 check("t_halt", {59'd0, bt.state_o, bt.halt_o, bt.timeout_o}, {59'd0, 3'd7, 2'b11});
    @(negedge clk); #1 check("t_sticky", {59'd0, bt.state_o, bt.halt_o, bt.timeout_o}, {59'd0, 3'd7, 2'b11});
    do_reset();
    check("t_clr", {62'd0, bt.halt_o, bt.timeout_o}, 64'd0);
    @(negedge clk); #1 check("t_ifreq2", {61'd0, bt.state_o}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bt.ifu_rvalid_i = i == 3;
      #1 check("t_ifwait2", {61'd0, bt.state_o}, 64'd2);
    end
    @(negedge clk); #1 check("t_exec", {60'd0, bt.state_o, bt.timeout_o}, {60'd0, 3'd3, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
